// File: rtl/pipelined_tree_adder.sv
// Pipelined multi-operand binary tree adder with valid/ready handshake and global stall.
// Sums N_OPS masked unsigned W-bit operands plus a carry-in. One register level per
// tree level, so the latency is LG = log2(N_OPS) cycles and the sum grows by LG bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set presented
//   in_ready   block can accept this cycle (combinational, independent of in_valid)
//   ops        operand i at bits [i*W +: W]
//   op_mask    bit i = 1 includes operand i, 0 forces it to zero
//   cin        carry-in, added once into lane 0 of the first level
//   out_valid  sum holds a result
//   out_ready  consumer accepts the result
//   sum        unsigned total, W+LG bits
module pipelined_tree_adder #(
  parameter int unsigned W = 16,
  parameter int unsigned N_OPS = 8,
  localparam int unsigned LG = $clog2(N_OPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_OPS*W-1:0]   ops,
  input  logic [N_OPS-1:0]     op_mask,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W+LG-1:0]      sum
);

  // Whole pipeline shifts together unless a finished result is waiting on the consumer.
  logic          adv;
  logic [LG-1:0] vld;

  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign out_valid = vld[LG-1];

  // Per-level valid bits; vld[k-1] qualifies level k.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int unsigned k = 1; k < LG; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

  // Level k holds N_OPS>>k partial sums, each W+k bits wide, which is enough to never overflow.
  for (genvar k = 1; k <= LG; k++) begin : g_st
    localparam int unsigned NL = N_OPS >> k;
    localparam int unsigned LW = W + k;

    logic [LW-1:0] lane [NL];
    logic [LW-1:0] nxt  [NL];
    logic          en;

    if (k == 1) begin : g_leaf
      // Masked operand pairs; carry-in folded into lane 0 so it is counted exactly once.
      always_comb begin
        for (int unsigned j = 0; j < NL; j++) begin
          nxt[j] = LW'(ops[(2*j)*W +: W] & {W{op_mask[2*j]}})
                 + LW'(ops[(2*j+1)*W +: W] & {W{op_mask[2*j+1]}})
                 + LW'(cin && (j == 0));
        end
      end
      // Data only moves when a real operand set enters; bubbles leave it don't-care.
      assign en = adv && in_valid;
    end else begin : g_node
      always_comb begin
        for (int unsigned j = 0; j < NL; j++) begin
          nxt[j] = LW'(g_st[k-1].lane[2*j]) + LW'(g_st[k-1].lane[2*j+1]);
        end
      end
      assign en = adv && vld[k-2];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned j = 0; j < NL; j++) begin
          lane[j] <= '0;
        end
      end else if (en) begin
        for (int unsigned j = 0; j < NL; j++) begin
          lane[j] <= nxt[j];
        end
      end
    end
  end

  assign sum = g_st[LG].lane[0];

endmodule

// File: tb/tb_pipelined_tree_adder.sv
// Directed and random bench for pipelined_tree_adder: an 8x16-bit instance and a 2x17-bit instance.
module tb_pipelined_tree_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // W=16, N_OPS=8 instance
  logic         iv, ir, ov, ordy, cin;
  logic [127:0] ops;
  logic [7:0]   mask;
  logic [18:0]  sum;

  // W=17, N_OPS=2 instance
  logic         b_iv, b_ir, b_ov, b_ordy, b_cin;
  logic [33:0]  b_ops;
  logic [1:0]   b_mask;
  logic [17:0]  b_sum;

  pipelined_tree_adder #(.W(16), .N_OPS(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .ops(ops), .op_mask(mask),
    .cin(cin), .out_valid(ov), .out_ready(ordy), .sum(sum)
  );

  pipelined_tree_adder #(.W(17), .N_OPS(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .ops(b_ops), .op_mask(b_mask),
    .cin(b_cin), .out_valid(b_ov), .out_ready(b_ordy), .sum(b_sum)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int incount = 0;
  logic [18:0] outq[$];
  logic [18:0] expq[$];
  int outcyc[$];

  always @(posedge clk) cyc++;

  function automatic logic [18:0] model(input logic [127:0] o, input logic [7:0] m, input logic c);
    logic [18:0] s;
    s = 19'(c);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) s = s + 19'(o[i*16 +: 16]);
    end
    return s;
  endfunction

  function automatic logic [127:0] all_of(input int v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(v);
    return r;
  endfunction

  function automatic logic [127:0] seq_ops();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(i + 1);
    return r;
  endfunction

  // Transfers are sampled mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (iv && ir) begin
        incount++;
        expq.push_back(model(ops, mask, cin));
      end
      if (ov && ordy) begin
        outq.push_back(sum);
        outcyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [127:0] o, input logic [7:0] m, input logic c,
                         input logic [18:0] e, input string tag);
    int n;
    outq.delete();
    ops = o; mask = m; cin = c; iv = 1'b1;
    tick();
    iv = 1'b0;
    n = 0;
    while (!ov && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_sum"}, 32'(sum), 32'(e));
    tick();
    chk({tag, "_once_v"}, 32'(ov), 32'd0);
    chk({tag, "_once_n"}, 32'(outq.size()), 32'd1);
  endtask

  initial begin
    int base;
    int sc;
    logic stalled;
    logic pv, pr;
    logic [18:0] ps;
    int nmin;

    rst = 1'b1;
    iv = 1'b0; ordy = 1'b1; ops = '0; mask = '0; cin = 1'b0;
    b_iv = 1'b0; b_ordy = 1'b1; b_ops = '0; b_mask = '0; b_cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ir", 32'(ir), 32'd1);
    chk("rst_b_ov", 32'(b_ov), 32'd0);
    chk("rst_b_sum", 32'(b_sum), 32'd0);

    // Full-scale operands with carry-in
    run_one(all_of(16'hFFFF), 8'hFF, 1'b1, 19'h7FFF9, "max");

    // Masking
    run_one(seq_ops(), 8'hFF, 1'b0, 19'd36, "seq_all");
    run_one(seq_ops(), 8'h0F, 1'b0, 19'd10, "seq_lo");
    run_one(seq_ops(), 8'h00, 1'b1, 19'd1, "seq_none");

    // Five back-to-back sets with a four-cycle consumer stall
    outq.delete(); outcyc.delete();
    base = incount; stalled = 1'b0; sc = 0;
    ordy = 1'b1; mask = 8'hFF; cin = 1'b0; iv = 1'b1; ops = all_of(1);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (incount - base < 5) begin
        iv = 1'b1;
        ops = all_of(incount - base + 1);
      end else begin
        iv = 1'b0;
      end
      if (ov && !stalled) begin
        stalled = 1'b1; ordy = 1'b0; sc = 4;
      end
      if (sc > 0) begin
        #1;
        chk("stall_sum", 32'(sum), 32'd8);
        chk("stall_ir", 32'(ir), 32'd0);
        sc--;
      end else begin
        ordy = 1'b1;
      end
    end
    chk("burst_n", 32'(outq.size()), 32'd5);
    for (int i = 0; i < 5 && i < outq.size(); i++) begin
      chk("burst_sum", 32'(outq[i]), 32'(8 * (i + 1)));
      if (i > 0) chk("burst_gap", 32'(outcyc[i] - outcyc[i-1]), 32'd1);
    end

    // Reset while two sets are in flight; a set offered during reset must be dropped
    outq.delete();
    ordy = 1'b1; mask = 8'hFF; cin = 1'b0; iv = 1'b1; ops = all_of(1);
    tick();
    ops = all_of(3);
    tick();
    ops = all_of(5); rst = 1'b1;
    tick();
    rst = 1'b0; iv = 1'b0;
    chk("mid_rst_ov", 32'(ov), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mid_rst_stale", 32'(ov), 32'd0);
    end
    chk("mid_rst_none", 32'(outq.size()), 32'd0);
    run_one(all_of(2), 8'hFF, 1'b0, 19'd16, "post_rst");

    // Two-operand, single-stage instance
    b_ops = {17'h0F0AE, 17'h0DE3A}; b_mask = 2'b11; b_cin = 1'b0; b_iv = 1'b1;
    tick();
    chk("n2_v0", 32'(b_ov), 32'd1);
    chk("n2_c0", 32'(b_sum), 32'h1CEE8);
    b_cin = 1'b1;
    tick();
    chk("n2_c1", 32'(b_sum), 32'h1CEE9);
    b_ops = {17'h1FFFF, 17'h1FFFF};
    tick();
    chk("n2_max", 32'(b_sum), 32'h3FFFF);
    b_ops = {17'h0F0AE, 17'h0DE3A}; b_mask = 2'b01; b_cin = 1'b0;
    tick();
    chk("n2_mask", 32'(b_sum), 32'h0DE3A);
    b_iv = 1'b0;
    tick();
    chk("n2_drain", 32'(b_ov), 32'd0);

    // Random traffic against the scoreboard
    expq.delete(); outq.delete();
    for (int c = 0; c < 10000; c++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      ops  = {$urandom, $urandom, $urandom, $urandom};
      mask = 8'($urandom);
      cin  = 1'($urandom_range(0, 1));
      #1;
      pv = ov; ps = sum; pr = ordy;
      tick();
      if (pv && !pr) begin
        chk("rnd_hold_v", 32'(ov), 32'd1);
        chk("rnd_hold_s", 32'(sum), 32'(ps));
      end
    end
    iv = 1'b0; ordy = 1'b1;
    repeat (8) tick();
    chk("rnd_count", 32'(outq.size()), 32'(expq.size()));
    nmin = (outq.size() < expq.size()) ? outq.size() : expq.size();
    for (int i = 0; i < nmin; i++) begin
      chk("rnd_sum", 32'(outq[i]), 32'(expq[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
